// File: rtl/main_mem_scheduler.sv
// Owns the single main-memory port behind the write-through cache: buffers stores in a
// small FIFO and schedules them against refill reads without letting a read pass a matching store.
module main_mem_scheduler #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_full,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_idle,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata
);
  localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(WBUF_DEPTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

  state_t                r_state;
  logic [ADDR_W-1:0]     r_buf_addr [WBUF_DEPTH];
  logic [DATA_W-1:0]     r_buf_data [WBUF_DEPTH];
  logic [WBUF_DEPTH-1:0] r_buf_valid;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic                  r_rd_valid;
  logic [DATA_W-1:0]     r_rd_data;

  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_match;
  logic [WBUF_DEPTH-1:0] w_hits;

  // Full comes from the registered count, so a same-cycle pop never frees room for a push.
  assign w_full = (r_count == CNT_W'(WBUF_DEPTH));
  assign w_push = i_wr_req && !w_full;
  assign w_pop  = (r_state == ST_WRITE) && i_mem_ack;

  always_comb begin
    w_hits = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      w_hits[i] = r_buf_valid[i] && (r_buf_addr[i] == i_rd_addr);
    end
  end
  assign w_match = |w_hits;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_buf_valid <= '0;
    end else begin
      if (w_push) begin
        r_buf_addr[r_tail]  <= i_wr_addr;
        r_buf_data[r_tail]  <= i_wr_data;
        r_buf_valid[r_tail] <= 1'b1;
        r_tail              <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_buf_valid[r_head] <= 1'b0;
        r_head              <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A read goes first only when the buffer is not full and holds no store to its word;
  // any other pending work drains the head store (full guard, RAW drain, plain drain).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_rd_req && !w_full && !w_match) begin
            r_state    <= ST_READ;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= i_rd_addr;
          end else if (r_count != '0) begin
            r_state     <= ST_WRITE;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_buf_addr[r_head];
            r_mem_wdata <= r_buf_data[r_head];
          end
        end
        ST_WRITE: begin
          if (i_mem_ack) begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
          end
        end
        ST_READ: begin
          if (i_mem_ack) begin
            r_state    <= ST_IDLE;
            r_mem_req  <= 1'b0;
            r_rd_valid <= 1'b1;
            r_rd_data  <= i_mem_rdata;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_wr_full   = w_full;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = r_rd_data;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_idle      = (r_count == '0) && (r_state == ST_IDLE) && !r_mem_req;

endmodule
